// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel deserializer with double buffering.
// Serial bits are collected in a shift register. Completed words move to
// an output register that the parallel sink drains through a valid/ready
// handshake. A second complete word can wait in the shift register (HOLD)
// while the sink stalls. In that state the serial side is stopped.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. Valid, once raised, holds its data
// stable until the transfer. Ready never depends combinationally on the
// valid of the same port.
module s2p_deser #(
    parameter int NUM       = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [NUM-1:0] p_data,
    output logic           p_valid,
    input  logic           p_ready
);

    localparam int CW = (NUM > 2) ? $clog2(NUM) : 1;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [NUM-1:0]  r_shift;
    logic [NUM-1:0]  r_pdata;
    logic            r_pvalid;

    logic            w_accept;
    logic            w_last;
    logic            w_take_out;
    logic            w_out_free;
    logic [CW-1:0]   w_pos;
    logic [NUM-1:0]  w_shift_next;

    // Serial side is open only while collecting and out of reset.
    assign s_ready    = !rst && (r_state == ST_COLLECT);
    assign w_accept   = s_valid && s_ready;
    assign w_last     = (r_cnt == CW'(NUM - 1));
    assign w_take_out = r_pvalid && p_ready;
    assign w_out_free = !r_pvalid || p_ready;

    // Bit k of a word lands at k, or at NUM-1-k when the stream is MSB first.
    assign w_pos = (MSB_FIRST != 0) ? (CW'(NUM - 1) - r_cnt) : r_cnt;

    assign p_data  = r_pdata;
    assign p_valid = r_pvalid;

    // Shift register with the incoming bit dropped into its slot.
    always_comb begin
        w_shift_next        = r_shift;
        w_shift_next[w_pos] = s_data;
    end

    // Control FSM, bit counter, shift register and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_COLLECT;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_pdata  <= '0;
            r_pvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    // Consumption clears valid. A word finishing on the same
                    // edge sets it again below, so the new load wins.
                    if (w_take_out) begin
                        r_pvalid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_shift <= w_shift_next;
                        if (w_last) begin
                            r_cnt <= '0;
                            if (w_out_free) begin
                                r_pdata  <= w_shift_next;
                                r_pvalid <= 1'b1;
                            end else begin
                                // Output is still occupied: park the word here.
                                r_state <= ST_HOLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Parked word moves out as soon as the sink takes the old one.
                    if (w_take_out) begin
                        r_pdata  <= r_shift;
                        r_pvalid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_deser.sv
// Bench for s2p_deser: one LSB-first and one MSB-first instance share the
// same serial stream and sink. The reference model is a queue of completed
// words per instance. Its occupancy alone gives the expected s_ready and
// p_valid. Its head gives the expected p_data.
module tb_s2p_deser;
    localparam int NUM = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_data = 1'b0;
    logic           s_valid = 1'b0;
    logic           p_ready = 1'b0;
    logic [1:0]     s_rdy;
    logic [1:0]     p_vld;
    logic [NUM-1:0] p_dat0;
    logic [NUM-1:0] p_dat1;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int pr_mode = 0;

    logic [NUM-1:0] exp_q0[$];
    logic [NUM-1:0] exp_q1[$];
    int             acc_n[2];
    logic [NUM-1:0] acc_w[2];

    // clock / reset block
    always #5 clk = ~clk;

    s2p_deser #(.NUM(NUM), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_rdy[0]), .p_data(p_dat0), .p_valid(p_vld[0]), .p_ready(p_ready)
    );

    s2p_deser #(.NUM(NUM), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_rdy[1]), .p_data(p_dat1), .p_valid(p_vld[1]), .p_ready(p_ready)
    );

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, id, act, exp, $time);
        end
    endtask

    function automatic int qsz(input int id);
        return (id == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [NUM-1:0] qhd(input int id);
        if (id == 0) return exp_q0[0];
        return exp_q1[0];
    endfunction

    task automatic qpop(input int id);
        if (id == 0) void'(exp_q0.pop_front());
        else void'(exp_q1.pop_front());
    endtask

    task automatic qpush(input int id, input logic [NUM-1:0] w);
        if (id == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
    endtask

    task automatic qclr(input int id);
        if (id == 0) exp_q0.delete();
        else exp_q1.delete();
    endtask

    // scoreboard / monitor: compare on the falling edge, then advance the
    // model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int id = 0; id < 2; id++) begin
                int sz;
                int pos;
                logic [NUM-1:0] pd;
                pd = (id == 0) ? p_dat0 : p_dat1;
                sz = qsz(id);
                check("s_ready", id, 32'(s_rdy[id]), 32'(!rst && sz < 2));
                check("p_valid", id, 32'(p_vld[id]), 32'(sz >= 1));
                if (sz >= 1) check("p_data", id, 32'(pd), 32'(qhd(id)));
                if (rst) begin
                    qclr(id);
                    acc_n[id] = 0;
                    acc_w[id] = '0;
                end else begin
                    if (sz >= 1 && p_ready) qpop(id);
                    if (s_valid && sz < 2) begin
                        pos = (id == 0) ? acc_n[id] : (NUM - 1 - acc_n[id]);
                        acc_w[id][pos] = s_data;
                        acc_n[id]++;
                        if (acc_n[id] == NUM) begin
                            qpush(id, acc_w[id]);
                            acc_n[id] = 0;
                            acc_w[id] = '0;
                        end
                    end
                end
            end
        end
    end

    // sink driver: 0 = stall, 1 = always ready, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #3;
            case (pr_mode)
                0: p_ready = 1'b0;
                1: p_ready = 1'b1;
                default: p_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            s_data = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        logic ok;
        n = 0;
        s_valid = 1'b1;
        s_data = b;
        forever begin
            @(negedge clk);
            ok = s_rdy[0];
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL send_timeout: s_ready stayed %0b, required 1 within 300 cycles", s_rdy[0]);
                break;
            end
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per bit, 2 random 0..2 idles
    task automatic send_word(input logic [NUM-1:0] w, input int gap_mode);
        for (int i = 0; i < NUM; i++) begin
            send_bit(w[i]);
            if (gap_mode == 1) idle(1);
            else if (gap_mode == 2) idle($urandom_range(0, 2));
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        pr_mode = 1;
        idle(6);
    endtask

    initial begin
        // reset held over two rising edges
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_p_data", 0, 32'(p_dat0), 32'h0);
        check("rst_p_data", 1, 32'(p_dat1), 32'h0);
        @(posedge clk);
        #1;

        // single word, continuous valid, sink always ready
        pr_mode = 1;
        idle(1);
        send_word(8'd63, 0);
        idle(3);

        // valid toggling every cycle
        send_word(8'd52, 1);
        idle(3);

        // full backpressure: two words absorbed, then serial side stops
        pr_mode = 0;
        idle(2);
        send_word(8'd7, 0);
        send_word(8'd52, 0);
        idle(4);
        pr_mode = 1;
        @(posedge clk);
        #1;
        pr_mode = 0;
        idle(4);
        drain();

        // reset in the middle of a word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        send_word(8'd7, 0);
        idle(3);

        // reset while a word is parked in HOLD
        pr_mode = 0;
        idle(2);
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        idle(2);
        do_reset();
        pr_mode = 1;
        send_word(8'hC3, 0);
        idle(3);

        // random words, random gaps, random sink stalls
        pr_mode = 2;
        for (int k = 0; k < 40; k++) begin
            send_word(NUM'($urandom_range(0, 255)), $urandom_range(0, 2));
        end
        idle(2);
        drain();
        idle(20);
        check("leftover_words", 0, 32'(exp_q0.size()), 32'h0);
        check("leftover_words", 1, 32'(exp_q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
